// File: rtl/wheel_tick_counter_if.sv
// Bundle of the wheel-encoder front end signals.
//
// Parameters:
//   CNT_W    width of the snapshot counts
//
// Signals:
//   en                 sample-window timer enable (driven by master)
//   enc_l_a, enc_l_b   left encoder channels, asynchronous (driven by master)
//   enc_r_a, enc_r_b   right encoder channels, asynchronous (driven by master)
//   count_l, count_r   coherent count snapshots (driven by slave)
//   dv                 one-cycle strobe, snapshots updated this cycle (driven by slave)
//   err_l, err_r       sticky illegal-transition flags (driven by slave)
//
// Modports:
//   master  the side that supplies the encoders and enable (e.g. a bench or pad ring)
//   slave   the counter itself
interface wheel_tick_counter_if #(
  parameter int unsigned CNT_W = 64
);
  logic             en;
  logic             enc_l_a;
  logic             enc_l_b;
  logic             enc_r_a;
  logic             enc_r_b;
  logic [CNT_W-1:0] count_l;
  logic [CNT_W-1:0] count_r;
  logic             dv;
  logic             err_l;
  logic             err_r;

  modport master (
    output en,
    output enc_l_a,
    output enc_l_b,
    output enc_r_a,
    output enc_r_b,
    input  count_l,
    input  count_r,
    input  dv,
    input  err_l,
    input  err_r
  );

  modport slave (
    input  en,
    input  enc_l_a,
    input  enc_l_b,
    input  enc_r_a,
    input  enc_r_b,
    output count_l,
    output count_r,
    output dv,
    output err_l,
    output err_r
  );
endinterface

// File: rtl/wheel_tick_counter.sv
// Quadrature front end for the left and right wheel encoders.
//
// Each encoder pair is synchronized (2 FF), optionally glitch filtered, then x4 decoded into a
// signed CNT_W-bit running count that wraps modulo 2^CNT_W. A free-running sample-window timer
// (advancing only while en=1) wraps every PERIOD clocks; on the wrap edge both running counts are
// copied into the snapshot registers together and dv pulses for one cycle.
//
// Parameters:
//   CNT_W    width of running counts and snapshots (two's complement)
//   PERIOD   clocks per sample window, 2..2^32-1
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   wheel_tick_counter_if.slave: en, enc_{l,r}_{a,b} in; count_l, count_r, dv, err_l,
//         err_r out
//
// Build option:
//   ENC_GLITCH_FILTER_EN  when defined, each synchronized channel must hold its value for three
//                         consecutive clocks before the decoder sees it (edge-to-count latency
//                         becomes 5 clocks instead of 3).
module wheel_tick_counter #(
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned PERIOD = 50000
) (
  input logic                 clk,
  input logic                 rst,
  wheel_tick_counter_if.slave bus
);

  localparam int unsigned NumWheels = 2;
  localparam int unsigned WheelL    = 0;
  localparam int unsigned WheelR    = 1;

  // Clocks after reset release before the decoder input holds a genuine encoder sample rather
  // than pipeline reset values. The first genuine sample primes prev without counting.
`ifdef ENC_GLITCH_FILTER_EN
  localparam logic [2:0] WarmCycles = 3'd4;
`else
  localparam logic [2:0] WarmCycles = 3'd2;
`endif

  localparam logic [31:0] TimerMax = 32'(PERIOD - 1);

  // Gray code position along the forward sequence 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Synchronizers ({a, b} per wheel)
  // ---------------------------------------------------------------------------------------------
  logic [1:0] enc_raw [NumWheels];
  logic [1:0] sync1_q [NumWheels];
  logic [1:0] sync2_q [NumWheels];
  logic [1:0] dec_in  [NumWheels];

  assign enc_raw[WheelL] = {bus.enc_l_a, bus.enc_l_b};
  assign enc_raw[WheelR] = {bus.enc_r_a, bus.enc_r_b};

  always_ff @(posedge clk) begin
    for (int w = 0; w < NumWheels; w++) begin
      if (rst) begin
        sync1_q[w] <= 2'b00;
        sync2_q[w] <= 2'b00;
      end else begin
        sync1_q[w] <= enc_raw[w];
        sync2_q[w] <= sync1_q[w];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Optional glitch filter
  // ---------------------------------------------------------------------------------------------
`ifdef ENC_GLITCH_FILTER_EN
  logic [1:0] hist1_q [NumWheels];
  logic [1:0] hist2_q [NumWheels];
  logic [1:0] filt_q  [NumWheels];
  logic [1:0] filt_d  [NumWheels];
  logic [1:0] agree   [NumWheels];

  // A channel passes only once the current synchronized bit and its two predecessors agree;
  // otherwise the last accepted value is held. The accepted value is used combinationally so the
  // filter adds two clocks of latency, not three.
  always_comb begin
    for (int w = 0; w < NumWheels; w++) begin
      agree[w]  = ~(sync2_q[w] ^ hist1_q[w]) & ~(hist1_q[w] ^ hist2_q[w]);
      filt_d[w] = (agree[w] & sync2_q[w]) | (~agree[w] & filt_q[w]);
      dec_in[w] = filt_d[w];
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < NumWheels; w++) begin
      if (rst) begin
        hist1_q[w] <= 2'b00;
        hist2_q[w] <= 2'b00;
        filt_q[w]  <= 2'b00;
      end else begin
        hist1_q[w] <= sync2_q[w];
        hist2_q[w] <= hist1_q[w];
        filt_q[w]  <= filt_d[w];
      end
    end
  end
`else
  always_comb begin
    for (int w = 0; w < NumWheels; w++) begin
      dec_in[w] = sync2_q[w];
    end
  end
`endif

  // ---------------------------------------------------------------------------------------------
  // Priming and x4 decode
  // ---------------------------------------------------------------------------------------------
  logic [2:0]           warm_q, warm_d;
  logic                 warm_done;
  logic [NumWheels-1:0] primed_q, primed_d;
  logic [NumWheels-1:0] err_q, err_d;
  logic [1:0]           prev_q [NumWheels];
  logic [1:0]           step   [NumWheels];
  logic [CNT_W-1:0]     cnt_q  [NumWheels];
  logic [CNT_W-1:0]     cnt_d  [NumWheels];

  always_comb begin
    warm_done = (warm_q == WarmCycles);
    warm_d    = warm_done ? warm_q : warm_q + 3'd1;
    for (int w = 0; w < NumWheels; w++) begin
      cnt_d[w]    = cnt_q[w];
      err_d[w]    = err_q[w];
      primed_d[w] = primed_q[w] | warm_done;
      step[w]     = gray_pos(dec_in[w]) - gray_pos(prev_q[w]);
      // Until primed, prev is merely loaded; nothing is counted or flagged.
      if (primed_q[w]) begin
        unique case (step[w])
          2'd1:    cnt_d[w] = cnt_q[w] + CNT_W'(1);
          2'd3:    cnt_d[w] = cnt_q[w] - CNT_W'(1);
          2'd2:    err_d[w] = 1'b1;  // both channels moved: position unknown, count held
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q   <= 3'd0;
      primed_q <= '0;
      err_q    <= '0;
    end else begin
      warm_q   <= warm_d;
      primed_q <= primed_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < NumWheels; w++) begin
      if (rst) begin
        prev_q[w] <= 2'b00;
        cnt_q[w]  <= '0;
      end else begin
        prev_q[w] <= dec_in[w];
        cnt_q[w]  <= cnt_d[w];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Sample-window timer and snapshots
  // ---------------------------------------------------------------------------------------------
  logic [31:0]      timer_q, timer_d;
  logic             wrap;
  logic [CNT_W-1:0] snap_l_q, snap_l_d;
  logic [CNT_W-1:0] snap_r_q, snap_r_d;
  logic             dv_q;

  always_comb begin
    wrap    = bus.en && (timer_q == TimerMax);
    timer_d = timer_q;
    if (bus.en) begin
      timer_d = wrap ? 32'd0 : timer_q + 32'd1;
    end
    // Capture next-state counts so a tick decoded on the wrap edge lands in this window.
    snap_l_d = wrap ? cnt_d[WheelL] : snap_l_q;
    snap_r_d = wrap ? cnt_d[WheelR] : snap_r_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= 32'd0;
      snap_l_q <= '0;
      snap_r_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      snap_l_q <= snap_l_d;
      snap_r_q <= snap_r_d;
      dv_q     <= wrap;
    end
  end

  assign bus.count_l = snap_l_q;
  assign bus.count_r = snap_r_q;
  assign bus.dv      = dv_q;
  assign bus.err_l   = err_q[WheelL];
  assign bus.err_r   = err_q[WheelR];

endmodule

// File: doc/wheel_tick_counter.md
# wheel_tick_counter

Quadrature front end of the position path: decodes the left and right wheel encoders into signed 64-bit running tick counts and, once per fixed sample window, presents a coherent snapshot of both counts with a one-cycle data-valid strobe. Outputs feed the position subtractor directly:
- `count_l` drives operand A.
- `count_r` drives operand B.
- `dv` drives the subtractor's data-valid input.

## Interface
- `CNT_W`, 64 — width of running counts and snapshot outputs (two's complement).
- `PERIOD`, 50000 — clocks per sample window; legal range 2..2^32-1.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `en`  input  1  enables the sample-window timer. Decoding runs regardless of `en`.
- `enc_l_a`, `enc_l_b`  input  1 each  left encoder channels; asynchronous.
- `enc_r_a`, `enc_r_b`  input  1 each  right encoder channels; asynchronous.
- `count_l`  output  CNT_W  left count snapshot.
- `count_r`  output  CNT_W  right count snapshot.
- `dv`  output  1  one-cycle pulse: snapshots updated this cycle.
- `err_l`, `err_r`  output  1 each  sticky illegal-transition flags.

## Operation
- Synchronization:
  - Each encoder input passes through a 2-FF synchronizer. Flops reset to 0.
- Priming:
  - Per wheel, a `primed` flag is cleared by `rst`.
  - The first synchronized sample after reset only loads the previous-state register (`prev`). No count change, no error.
  - `primed` is then set.
- Decode (x4), per wheel, comparing `prev` (a,b) to the current sample:
  - Forward sequence 00→01→11→10→00: +1.
  - Reverse sequence: −1.
  - Unchanged: 0.
  - Both bits changed: illegal. Count unchanged, error flag set.
  - `prev` updates every cycle.
- Running counters:
  - Signed CNT_W, reset 0.
  - Wrap modulo 2^CNT_W with no saturation: 0x7FFF…F +1 → 0x8000…0; 0 −1 → 0xFFFF…F.
- Window timer:
  - Counts 0..PERIOD-1 while `en`=1. Holds its value while `en`=0.
  - On the cycle it wraps PERIOD-1→0:
    - `count_l` and `count_r` load the running counts, including any tick decoded on that same edge.
    - `dv`=1 for exactly one cycle.
- Snapshots:
  - Both wheels are always captured on the same edge, so `count_l` and `count_r` belong to the same window.
  - Snapshots hold their value between strobes; they are stable for the full `dv` cycle and the following negedge.
- Errors:
  - `err_l` / `err_r` stay set until `rst`.
  - An illegal transition never blocks counting on later legal transitions.
- Reset values: `count_l`=0, `count_r`=0, `dv`=0, `err_l`=0, `err_r`=0; window timer 0; running counts 0.
- Reset mid-window: timer, counts and flags clear on the next edge. No `dv` is issued for the aborted window.

## Timing
- Encoder edge to running-count update: 3 clocks (2 synchronizer stages + 1 decode register).
- With `en` high continuously from the first cycle after reset release, the first `dv` occurs PERIOD cycles later. After that, `dv` repeats every PERIOD cycles.
- Dropping `en` on the wrap cycle: the wrap still completes and `dv` fires. The timer then holds at 0.
- Consecutive legal transitions on every clock are all counted; maximum tick rate is 1 per clock per wheel.
- `dv` is never asserted two cycles in a row. This is guaranteed by PERIOD ≥ 2.

## Configuration
- `ENC_GLITCH_FILTER_EN` defined:
  - Each synchronized channel must hold the same value for 3 consecutive clocks before it is presented to the decoder.
  - Shorter pulses are discarded.
  - Edge-to-count latency becomes 5 clocks.
  - Filter registers reset to 0 and take part in priming; priming waits until the filter output is valid.
- Undefined: no filter. Latency is 3 clocks, as above.

## Test plan
- Forward count: PERIOD=8, `en`=1; left wheel stepped forward through 10 transitions, one per 4 clocks, starting after reset.
  - `count_l`=10, `count_r`=0, `err_l`=0 at the first `dv` after the last step has propagated.
  - `dv` pulses exactly every 8 clocks.
- Reverse and wrap: preload by stepping the right wheel reverse 3 transitions from 0.
  - `count_r`=0xFFFF_FFFF_FFFF_FFFD at the next `dv`.
  - Then 3 forward transitions → `count_r`=0 at the following `dv`.
- Illegal step: left channels 00→11 in one clock.
  - `err_l`=1 three clocks later, `count_l` unchanged.
  - A subsequent legal 11→10 still gives +1; `err_l` stays 1 until `rst`.
- Priming: hold `enc_l`=11 through reset and release.
  - `err_l`=0 and `count_l`=0 at the first `dv`.
- Same-edge tick and sample: time a forward transition so its count update lands on the wrap edge.
  - The snapshot taken on that `dv` includes the tick.
  - `rst` asserted mid-window 3 clocks later clears all outputs to 0 on the next edge; no `dv` until PERIOD clocks after release.
- Glitch filter, with `ENC_GLITCH_FILTER_EN` defined: 2-clock pulse on `enc_r_a`.
  - `count_r` unchanged.
  - A 3-clock-stable legal step gives +1, visible 5 clocks after the input edge.
